dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Bus-side responder for the CPU data-memory port: word-organised, byte-enabled
//   data RAM behind the addr/data/byteen/we/re bus driven by the core's load/store unit.
//   Accepts one request at a time, inserts WAIT_STATES wait cycles and returns a
//   one-cycle ready pulse with read data or an error flag.
//   Read data is returned as the full aligned word; lane extraction and sign
//   extension stay in the core.
// PARAMETERS
//   WIDTH        32        data/address width (only 32 supported)
//   DEPTH_WORDS  1024      RAM depth in 32-bit words (power of 2)
//   BASE_ADDR    32'h0     byte address of word 0 (aligned to 4*DEPTH_WORDS)
//   WAIT_STATES  1         extra cycles between accept and ready (0..15)
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   bus_addr      in   WIDTH  byte address; bits [1:0] ignored (lanes come from byteen)
//   bus_data_in   in   WIDTH  write data, already lane-shifted by the initiator
//   bus_byteen    in   4      byte-lane enables, bit i = bits [8i+7:8i]
//   bus_we        in   1      write request
//   bus_re        in   1      read request
//   bus_data_out  out  WIDTH  read data; valid when bus_ready=1 and bus_err=0
//   bus_ready     out  1      one-cycle completion pulse
//   bus_err       out  1      completion with error; qualified by bus_ready
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, wait counter=0, bus_ready=0, bus_err=0,
//     bus_data_out=0; any pending write is dropped; RAM contents not cleared.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: if bus_re|bus_we, latch addr, data, byteen, we, re and the error check;
//       go to WAIT (counter=WAIT_STATES-1), or to RESP if WAIT_STATES==0.
//     WAIT: decrement counter; go to RESP on the edge after counter==0.
//     RESP: bus_ready=1 for exactly one cycle, then IDLE.
//   Latency: request sampled at edge N -> bus_ready high in cycle N+1+WAIT_STATES.
//   Bus inputs are ignored outside IDLE. The initiator holds its request until
//     ready, then drops it or presents a new one; a request seen in IDLE is
//     always a new transaction, giving back-to-back throughput of 1 per (2+WAIT_STATES).
//   Error check (latched at accept). Error if any of:
//     - addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
//     - byteen not in {0001,0010,0100,1000,0011,1100,1111}
//     - bus_we and bus_re both high
//   An error sets bus_err=1 with bus_ready, performs no RAM write and drives
//     bus_data_out=0.
//   Write: on the edge entering RESP, RAM[word] lane i <= bus_data_in lane i for
//     each enabled lane; other lanes are unchanged. A read accepted afterwards
//     sees the new data.
//   Read: bus_data_out <= RAM[(addr-BASE_ADDR)>>2] on the edge entering RESP,
//     all 4 lanes, independent of byteen.
//   bus_data_out holds its value until the next read or error response; a
//     write leaves it unchanged.
//   bus_err is 0 whenever bus_ready is 0.
//   Reset asserted in WAIT or RESP aborts the transaction: no write, no ready.
//     The first request after reset release is accepted normally.
// TESTING
//   1. WAIT_STATES=1: sw 0xDEADBEEF @0x10 (byteen 1111), then lw @0x10 ->
//      ready at accept+2 each time, err=0, data_out=0xDEADBEEF.
//   2. Word=0xDEADBEEF, sb data 0x0000AC00 byteen 0010 @0x11, then lw @0x10 ->
//      0xDEADACEF.
//   3. lw @BASE_ADDR+4*DEPTH_WORDS -> ready=1, err=1, data_out=0.
//      sh with byteen 0110 -> err=1 and RAM unchanged.
//   4. we=re=1 @0x20 -> err=1, word @0x20 unchanged on readback.
//   5. WAIT_STATES=0: back-to-back lw @0x0, @0x4 -> ready pulses 2 cycles apart,
//      no pulse wider than 1 cycle.
//   6. sw 0x12345678 @0x30, rst_n=0 during WAIT -> no ready, outputs 0.
//      After release, lw @0x30 returns the prior value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised, byte-enabled data RAM on the core's load/store bus.
// One request at a time. Each request gets WAIT_STATES wait cycles and then a
// one-cycle ready pulse that carries the read data or an error flag.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   bus_addr      byte address; bits [1:0] are ignored and lanes come from bus_byteen
//   bus_data_in   write data, already lane-shifted by the initiator
//   bus_byteen    byte-lane enables; bit i covers bits [8i+7:8i]
//   bus_we        write request
//   bus_re        read request
//   bus_data_out  full aligned read word; zero after an error, held otherwise
//   bus_ready     one-cycle completion pulse
//   bus_err       completion with error; only high together with bus_ready
module dmem_responder #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bus_addr,
   input  logic [WIDTH-1:0] bus_data_in,
   input  logic [3:0]       bus_byteen,
   input  logic             bus_we,
   input  logic             bus_re,
   output logic [WIDTH-1:0] bus_data_out,
   output logic             bus_ready,
   output logic             bus_err
);

   localparam int unsigned    AW       = $clog2(DEPTH_WORDS);
   localparam logic [WIDTH-1:0] SPAN   = WIDTH'(4 * DEPTH_WORDS);
   localparam logic [3:0]     CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [AW-1:0]    idx_q;
   logic [WIDTH-1:0] wdata_q;
   logic [3:0]       be_q;
   logic             we_q, re_q, txn_err_q;
   logic [WIDTH-1:0] dout_q;
   logic             ready_q, err_q;

   logic [WIDTH-1:0] mem [DEPTH_WORDS];

   // Decode of the request as presented on the bus.
   logic [WIDTH-1:0] offset;
   logic             in_range, be_ok, req, req_err, in_idle;

   assign offset   = bus_addr - WIDTH'(BASE_ADDR);
   assign in_range = offset < SPAN;
   assign req      = bus_we | bus_re;
   assign req_err  = !in_range || !be_ok || (bus_we && bus_re);
   assign in_idle  = (state_q == StIdle);

   always_comb begin
      be_ok = 1'b0;
      unique case (bus_byteen)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
         default:                   be_ok = 1'b0;
      endcase
   end

   logic unused_offset;
   assign unused_offset = ^{offset[WIDTH-1:AW+2], offset[1:0]};

   // With zero wait states the RAM access happens on the accepting edge,
   // before the latches are loaded, so the live bus values are used then.
   logic [AW-1:0]    t_idx;
   logic [WIDTH-1:0] t_data;
   logic [3:0]       t_be;
   logic             t_we, t_re, t_err, to_resp, mem_we;

   assign t_idx  = in_idle ? offset[AW+1:2] : idx_q;
   assign t_data = in_idle ? bus_data_in    : wdata_q;
   assign t_be   = in_idle ? bus_byteen     : be_q;
   assign t_we   = in_idle ? bus_we         : we_q;
   assign t_re   = in_idle ? bus_re         : re_q;
   assign t_err  = in_idle ? req_err        : txn_err_q;

   assign to_resp = (in_idle && req && (WAIT_STATES == 0)) ||
                    ((state_q == StWait) && (cnt_q == 4'd0));
   // Reset during the entering edge must not let a write through.
   assign mem_we  = rst_n && to_resp && t_we && !t_err;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         idx_q     <= '0;
         wdata_q   <= '0;
         be_q      <= 4'd0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         txn_err_q <= 1'b0;
         dout_q    <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (in_idle && req) begin
            idx_q     <= offset[AW+1:2];
            wdata_q   <= bus_data_in;
            be_q      <= bus_byteen;
            we_q      <= bus_we;
            re_q      <= bus_re;
            txn_err_q <= req_err;
         end
         ready_q <= to_resp;
         err_q   <= to_resp && t_err;
         if (to_resp) begin
            if (t_err)     dout_q <= '0;
            else if (t_re) dout_q <= mem[t_idx];
         end
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (t_be[i]) mem[t_idx][8*i +: 8] <= t_data[8*i +: 8];
         end
      end
   end

   assign bus_data_out = dout_q;
   assign bus_ready    = ready_q;
   assign bus_err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance with one wait state and one with none.
// A memory model indexed by word, plus the last returned read word per instance,
// predicts the error flag, read data and latency of every transaction.
module tb_dmem_responder;

   localparam longint BASE  = 0;
   localparam longint DEPTH = 1024;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0] addr0, din0, dout0, addr1, din1, dout1;
   logic [3:0]  be0, be1;
   logic        we0, re0, rdy0, err0, we1, re1, rdy1, err1;

   dmem_responder #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus_addr(addr0), .bus_data_in(din0), .bus_byteen(be0),
      .bus_we(we0), .bus_re(re0), .bus_data_out(dout0), .bus_ready(rdy0), .bus_err(err0)
   );

   dmem_responder #(.WAIT_STATES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus_addr(addr1), .bus_data_in(din1), .bus_byteen(be1),
      .bus_we(we1), .bus_re(re1), .bus_data_out(dout1), .bus_ready(rdy1), .bus_err(err1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem_m [int];
   logic [31:0] dout_m [2];
   logic [3:0]  good_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   logic [3:0]  bad_be  [9] = '{4'b0000, 4'b0101, 4'b0110, 4'b1010, 4'b1001, 4'b0111,
                                4'b1110, 4'b1011, 4'b1101};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy_of(input int d);  return d == 1 ? rdy1 : rdy0;   endfunction
   function automatic logic err_of(input int d);  return d == 1 ? err1 : err0;   endfunction
   function automatic logic [31:0] dout_of(input int d); return d == 1 ? dout1 : dout0; endfunction

   task automatic drive(input int d, input logic [31:0] a, input logic [31:0] data,
                        input logic [3:0] b, input logic w, input logic r);
      if (d == 1) begin
         addr1 = a; din1 = data; be1 = b; we1 = w; re1 = r;
      end else begin
         addr0 = a; din0 = data; be0 = b; we0 = w; re0 = r;
      end
   endtask

   function automatic bit model_err(input logic [31:0] a, input logic [3:0] b,
                                    input logic w, input logic r);
      bit ok_be = 1'b0;
      foreach (good_be[i]) if (good_be[i] == b) ok_be = 1'b1;
      return !(longint'(a) >= BASE && longint'(a) < BASE + 4 * DEPTH) || !ok_be || (w && r);
   endfunction

   function automatic int key_of(input int d, input logic [31:0] a);
      return d * 65536 + int'((longint'(a) - BASE) / 4);
   endfunction

   // One full transaction: issue, wait for ready, compare against the model, then
   // confirm the ready pulse lasted only one cycle.
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] data,
                      input logic [3:0] b, input logic w, input logic r);
      int lat = 0;
      bit e;
      logic [31:0] word;
      e = model_err(a, b, w, r);
      @(posedge clk); #1;
      drive(d, a, data, b, w, r);
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!rdy_of(d) && lat < 40);
      drive(d, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      if (e) begin
         dout_m[d] = 32'h0;
      end else begin
         if (w) begin
            word = mem_m.exists(key_of(d, a)) ? mem_m[key_of(d, a)] : 32'h0;
            for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = data[8*i +: 8];
            mem_m[key_of(d, a)] = word;
         end
         if (r) dout_m[d] = mem_m[key_of(d, a)];
      end
      chk("latency", 32'(lat), 32'(d + 1));
      chk("ready", {31'h0, rdy_of(d)}, 32'h1);
      chk("err", {31'h0, err_of(d)}, {31'h0, e});
      chk("data_out", dout_of(d), dout_m[d]);
      @(posedge clk); #1;
      chk("ready_width", {31'h0, rdy_of(d)}, 32'h0);
      chk("err_idle", {31'h0, err_of(d)}, 32'h0);
   endtask

   initial begin
      logic [31:0] a, data;
      logic [3:0]  b;
      int kind;

      rst_n = 1'b0;
      drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      dout_m[0] = 32'h0;
      dout_m[1] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready0", {31'h0, rdy0}, 32'h0);
      chk("rst_err0", {31'h0, err0}, 32'h0);
      chk("rst_dout0", dout0, 32'h0);
      chk("rst_ready1", {31'h0, rdy1}, 32'h0);
      chk("rst_err1", {31'h0, err1}, 32'h0);
      chk("rst_dout1", dout1, 32'h0);
      rst_n = 1'b1;

      // Store then load a full word.
      txn(1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0);
      txn(1, 32'h10, 32'h0, 4'b1111, 1'b0, 1'b1);
      chk("sw_lw", dout1, 32'hDEADBEEF);

      // Byte store into lane 1; the store itself leaves data_out alone.
      txn(1, 32'h11, 32'h0000AC00, 4'b0010, 1'b1, 1'b0);
      chk("sb_keeps_dout", dout1, 32'hDEADBEEF);
      txn(1, 32'h10, 32'h0, 4'b1111, 1'b0, 1'b1);
      chk("sb_merge", dout1, 32'hDEADACEF);

      // Out-of-range load, then a store with an illegal lane pattern.
      txn(1, 32'h1000, 32'h0, 4'b1111, 1'b0, 1'b1);
      chk("oor_dout", dout1, 32'h0);
      chk("oor_err_model", {31'h0, model_err(32'h1000, 4'b1111, 1'b0, 1'b1)}, 32'h1);
      txn(1, 32'h10, 32'h12345678, 4'b0110, 1'b1, 1'b0);
      txn(1, 32'h10, 32'h0, 4'b1111, 1'b0, 1'b1);
      chk("bad_be_no_write", dout1, 32'hDEADACEF);

      // Read and write requested together.
      txn(1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0);
      txn(1, 32'h20, 32'h11111111, 4'b1111, 1'b1, 1'b1);
      txn(1, 32'h20, 32'h0, 4'b1111, 1'b0, 1'b1);
      chk("we_re_no_write", dout1, 32'hCAFEF00D);

      // Zero wait states: back-to-back loads give pulses two cycles apart.
      txn(0, 32'h0, 32'hA5A50000, 4'b1111, 1'b1, 1'b0);
      txn(0, 32'h4, 32'h00005A5A, 4'b1111, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(0, 32'h0, 32'h0, 4'b1111, 1'b0, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         chk("b2b_ready", {31'h0, rdy0}, (c % 2 == 1) ? 32'h1 : 32'h0);
         if (c == 1) begin
            chk("b2b_data0", dout0, 32'hA5A50000);
            drive(0, 32'h4, 32'h0, 4'b1111, 1'b0, 1'b1);
         end
         if (c == 3) begin
            chk("b2b_data4", dout0, 32'h00005A5A);
            drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
         end
      end
      dout_m[0] = 32'h00005A5A;

      // Reset while a store waits: no ready, no write, outputs cleared.
      txn(1, 32'h30, 32'h0BADF00D, 4'b1111, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(1, 32'h30, 32'h12345678, 4'b1111, 1'b1, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_ready", {31'h0, rdy1}, 32'h0);
      chk("abort_err", {31'h0, err1}, 32'h0);
      chk("abort_dout", dout1, 32'h0);
      @(posedge clk); #1;
      chk("abort_ready_later", {31'h0, rdy1}, 32'h0);
      drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dout_m[0] = 32'h0;
      dout_m[1] = 32'h0;
      chk("abort_dout0", dout0, 32'h0);
      txn(1, 32'h30, 32'h0, 4'b1111, 1'b0, 1'b1);
      chk("abort_no_write", dout1, 32'h0BADF00D);

      // Random traffic over the first 16 words of each instance.
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 16; w++) txn(d, 32'(w * 4), $urandom(), 4'b1111, 1'b1, 1'b0);
         for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 15) * 4) | ($urandom() & 32'h3);
            data = $urandom();
            b    = good_be[$urandom_range(0, 6)];
            case (kind)
               0, 1, 2: txn(d, a, data, b, 1'b1, 1'b0);
               3, 4, 5: txn(d, a, data, b, 1'b0, 1'b1);
               6:       txn(d, 32'h1000 | $urandom(), data, b, 1'b0, 1'b1);
               7:       txn(d, a, data, bad_be[$urandom_range(0, 8)], 1'b1, 1'b0);
               8:       txn(d, a, data, b, 1'b1, 1'b1);
               default: txn(d, a, data, bad_be[$urandom_range(0, 8)], 1'b0, 1'b1);
            endcase
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
